// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that feeds one UART TX
// AXI4-Stream input from PORTS byte sources. A grant is held from the first
// byte of a packet to its tlast beat. A watchdog revokes a grant whose owner
// stops presenting data mid-packet.
// Optional feature: define UART_TX_ARB_SRC_HDR_EN to prefix every packet
// with a header byte {1'b1, zero-padded owner index}.
module uart_tx_arbiter #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [PORTS-1:0]              s_axis_tvalid,
   input  logic [PORTS-1:0]              s_axis_tlast,
   output logic [PORTS-1:0]              s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [PORTS-1:0]              grant,
   output logic                          abort,
   output logic [$clog2(PORTS)-1:0]      abort_port
);

   localparam int IW = $clog2(PORTS);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1
`ifdef UART_TX_ARB_SRC_HDR_EN
      , HDR = 2'd2
`endif
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   last;      // current owner while granted, previous owner in IDLE
   logic [IW-1:0]   sel;
   logic [IW-1:0]   cand;
   logic            found;
   logic [CW-1:0]   cnt;
   logic [CW:0]     cnt_inc;
   logic            xfer;
   logic            wd_fire;

`ifdef UART_TX_ARB_SRC_HDR_EN
   logic [DATA_WIDTH-1:0] hdr_byte;

   // Header byte: MSB set, owner index in the low bits
   always_comb begin
      hdr_byte                 = '0;
      hdr_byte[DATA_WIDTH-1]   = 1'b1;
      hdr_byte[IW-1:0]         = last;
   end
`endif

   // Round-robin scan: first requesting source starting after the last owner
   always_comb begin
      sel   = last;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= PORTS; k++) begin
         cand = IW'((int'(last) + k) % PORTS);
         if (!found && s_axis_tvalid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // Next-state and datapath mux; owner is only ever connected in PASS
   always_comb begin
      state_nxt     = state;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      xfer          = 1'b0;
      wd_fire       = 1'b0;
      cnt_inc       = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
      case (state)
         IDLE: begin
            if (found) begin
`ifdef UART_TX_ARB_SRC_HDR_EN
               state_nxt = HDR;
`else
               state_nxt = PASS;
`endif
            end
         end
`ifdef UART_TX_ARB_SRC_HDR_EN
         HDR: begin
            m_axis_tdata  = hdr_byte;
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) state_nxt = PASS;
         end
`endif
         PASS: begin
            m_axis_tdata         = s_axis_tdata[int'(last)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid        = s_axis_tvalid[last];
            s_axis_tready[last]  = m_axis_tready;
            xfer                 = s_axis_tvalid[last] && m_axis_tready;
            if (xfer && s_axis_tlast[last]) begin
               state_nxt = IDLE;
            end else if (TIMEOUT > 0 && !s_axis_tvalid[last] &&
                         cnt_inc == (CW+1)'(TIMEOUT)) begin
               wd_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Owner/grant bookkeeping, stall counter and abort reporting
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last       <= IW'(PORTS - 1);
         grant      <= '0;
         cnt        <= '0;
         abort      <= 1'b0;
         abort_port <= '0;
      end else begin
         abort <= wd_fire;
         if (wd_fire) abort_port <= last;
         if (state == IDLE && found) begin
            last  <= sel;
            grant <= PORTS'(1) << sel;
         end else if (state_nxt == IDLE) begin
            grant <= '0;
         end
         // counter only runs while the owner is silent in PASS
         if (state != PASS || xfer)
            cnt <= '0;
         else if (TIMEOUT > 0 && !s_axis_tvalid[last])
            cnt <= cnt_inc[CW-1:0];
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (PORTS=4, DATA_WIDTH=8, TIMEOUT=8). Sources are
// fed from per-port beat queues; expected {grant, byte} pairs are queued in
// the order the arbitration must produce them and popped on every m_axis
// handshake. Build with UART_TX_ARB_SRC_HDR_EN to exercise header bytes.
module tb_uart_tx_arbiter;

   localparam int PORTS = 4;
   localparam int DW    = 8;
   localparam int TO    = 8;
`ifdef UART_TX_ARB_SRC_HDR_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [PORTS*DW-1:0]   s_axis_tdata;
   logic [PORTS-1:0]      s_axis_tvalid;
   logic [PORTS-1:0]      s_axis_tlast;
   logic [PORTS-1:0]      s_axis_tready;
   logic [DW-1:0]         m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic [PORTS-1:0]      grant;
   logic                  abort;
   logic [1:0]            abort_port;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .grant(grant),
      .abort(abort), .abort_port(abort_port)
   );

   int                    n_cmp = 0;
   int                    n_err = 0;
   int                    cyc   = 0;
   logic                  rdy   = 1'b1;
   logic [DW:0]           srcq [PORTS][$];   // {tlast, tdata}
   logic [PORTS+DW-1:0]   exp_q[$];          // {grant, tdata}
   int                    xfer_cycs[$];

   function automatic logic [PORTS-1:0] oh(input int p);
      logic [PORTS-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   task automatic push_exp_hdr(input int p);
      if (HDR != 0) exp_q.push_back({oh(p), 8'h80 | 8'(p)});
   endtask

   task automatic push_beat(input int p, input logic [7:0] d, input logic l, input logic expect_it);
      srcq[p].push_back({l, d});
      if (expect_it) exp_q.push_back({oh(p), d});
   endtask

   task automatic push_pkt(input int p, input int len, input logic [7:0] base);
      push_exp_hdr(p);
      for (int k = 0; k < len; k++) push_beat(p, base + 8'(k), (k == len - 1), 1'b1);
   endtask

   // One clock: drive sources from queues, then observe handshakes before the edge
   task automatic cycle();
      logic [DW:0]         b;
      logic [PORTS+DW-1:0] e;
      @(negedge clk);
      for (int i = 0; i < PORTS; i++) begin
         if (srcq[i].size() > 0) begin
            b = srcq[i][0];
            s_axis_tvalid[i]           = 1'b1;
            s_axis_tlast[i]            = b[DW];
            s_axis_tdata[i*DW +: DW]   = b[DW-1:0];
         end else begin
            s_axis_tvalid[i]           = 1'b0;
            s_axis_tlast[i]            = 1'b0;
            s_axis_tdata[i*DW +: DW]   = '0;
         end
      end
      m_axis_tready = rdy;
      #1;
      cyc++;
      for (int i = 0; i < PORTS; i++)
         if (s_axis_tvalid[i] && s_axis_tready[i]) void'(srcq[i].pop_front());
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         xfer_cycs.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_extra: got grant=%b data=%h want nothing", grant, m_axis_tdata);
         end else begin
            e = exp_q.pop_front();
            if ({grant, m_axis_tdata} !== e) begin
               n_err++;
               $display("FAIL scoreboard: got grant=%b data=%h want grant=%b data=%h",
                        grant, m_axis_tdata, e[PORTS+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || srcq[0].size() > 0 || srcq[1].size() > 0 ||
              srcq[2].size() > 0 || srcq[3].size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
      end
   endtask

   task automatic wait_xfers(input int cnt, input int budget);
      int n = 0;
      while (xfer_cycs.size() < cnt && n < budget) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (xfer_cycs.size() != cnt) begin
         n_err++;
         $display("FAIL wait_xfers: got %0d transfers want %0d", xfer_cycs.size(), cnt);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < PORTS; i++) srcq[i].delete();
      exp_q.delete();
      rdy   = 1'b1;
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      xfer_cycs.delete();
   endtask

   task automatic test_reset();
      do_reset();
      cycle();
      n_cmp += 6;
      if (grant !== 4'b0)         begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant); end
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL rst_mdata: got %h want 00", m_axis_tdata); end
      if (s_axis_tready !== 4'b0) begin n_err++; $display("FAIL rst_sready: got %b want 0000", s_axis_tready); end
      if (abort !== 1'b0)         begin n_err++; $display("FAIL rst_abort: got %b want 0", abort); end
      if (abort_port !== 2'd0)    begin n_err++; $display("FAIL rst_abort_port: got %0d want 0", abort_port); end
   endtask

   task automatic test_contention();
      int L, d, want;
      L = HDR + 2;
      xfer_cycs.delete();
      push_pkt(0, 2, 8'hA0);
      push_pkt(2, 2, 8'hB0);
      drain(40);
      n_cmp++;
      if (xfer_cycs.size() != 2 * L) begin
         n_err++;
         $display("FAIL cont_count: got %0d want %0d", xfer_cycs.size(), 2 * L);
      end else begin
         for (int i = 0; i < 2 * L - 1; i++) begin
            d    = xfer_cycs[i+1] - xfer_cycs[i];
            want = (i == L - 1) ? 2 : 1;
            n_cmp++;
            if (d !== want) begin
               n_err++;
               $display("FAIL cont_gap[%0d]: got %0d want %0d", i, d, want);
            end
         end
      end
   endtask

   task automatic test_single();
      int c0, d;
      c0 = cyc;
      xfer_cycs.delete();
      push_exp_hdr(1);
      push_beat(1, 8'h11, 1'b0, 1'b1);
      push_beat(1, 8'h22, 1'b0, 1'b1);
      push_beat(1, 8'h33, 1'b1, 1'b1);
      drain(30);
      n_cmp++;
      if (xfer_cycs.size() != HDR + 3) begin
         n_err++;
         $display("FAIL single_count: got %0d want %0d", xfer_cycs.size(), HDR + 3);
      end else begin
         d = xfer_cycs[0] - c0;
         n_cmp++;
         if (d !== 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", d); end
         for (int i = 0; i < HDR + 2; i++) begin
            d = xfer_cycs[i+1] - xfer_cycs[i];
            n_cmp++;
            if (d !== 1) begin n_err++; $display("FAIL single_gap[%0d]: got %0d want 1", i, d); end
         end
      end
      cycle();
      n_cmp += 2;
      if (grant !== 4'b0)         begin n_err++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b want 0", m_axis_tvalid); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < PORTS; p++)
            push_pkt(p, 1, 8'(16 * p + r));
      drain(150);
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      held = 8'hC2 - 8'(HDR);
      xfer_cycs.delete();
      push_pkt(0, 4, 8'hC0);
      wait_xfers(HDR + 2, 20);
      rdy = 1'b0;
      repeat (5) begin
         cycle();
         n_cmp += 4;
         if (s_axis_tready !== 4'b0) begin n_err++; $display("FAIL bp_sready: got %b want 0000", s_axis_tready); end
         if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_mvalid: got %b want 1", m_axis_tvalid); end
         if (m_axis_tdata !== held)  begin n_err++; $display("FAIL bp_data: got %h want %h", m_axis_tdata, held); end
         if (abort !== 1'b0)         begin n_err++; $display("FAIL bp_abort: got %b want 0", abort); end
      end
      rdy = 1'b1;
      drain(20);
   endtask

   task automatic test_watchdog();
      do_reset();
      push_exp_hdr(3);
      push_beat(3, 8'h3C, 1'b0, 1'b1);
      wait_xfers(HDR + 1, 20);
      push_pkt(0, 1, 8'h0A);
      for (int k = 1; k <= TO; k++) begin
         cycle();
         n_cmp += 2;
         if (abort !== 1'b0)     begin n_err++; $display("FAIL wd_early_abort[%0d]: got %b want 0", k, abort); end
         if (grant !== 4'b1000)  begin n_err++; $display("FAIL wd_hold_grant[%0d]: got %b want 1000", k, grant); end
      end
      cycle();
      n_cmp += 3;
      if (abort !== 1'b1)      begin n_err++; $display("FAIL wd_abort: got %b want 1", abort); end
      if (abort_port !== 2'd3) begin n_err++; $display("FAIL wd_abort_port: got %0d want 3", abort_port); end
      if (grant !== 4'b0)      begin n_err++; $display("FAIL wd_idle_grant: got %b want 0000", grant); end
      cycle();
      n_cmp += 3;
      if (abort !== 1'b0)      begin n_err++; $display("FAIL wd_pulse: got %b want 0", abort); end
      if (abort_port !== 2'd3) begin n_err++; $display("FAIL wd_port_held: got %0d want 3", abort_port); end
      if (grant !== 4'b0001)   begin n_err++; $display("FAIL wd_next_grant: got %b want 0001", grant); end
      drain(20);

      // reset in the middle of a port 1 packet: everything goes quiet
      xfer_cycs.delete();
      push_exp_hdr(1);
      push_beat(1, 8'h71, 1'b0, 1'b1);
      push_beat(1, 8'h72, 1'b0, 1'b0);
      push_beat(1, 8'h73, 1'b1, 1'b0);
      wait_xfers(HDR + 1, 20);
      rst_n = 1'b0;
      cycle();
      cycle();
      n_cmp += 6;
      if (grant !== 4'b0)         begin n_err++; $display("FAIL mid_rst_grant: got %b want 0000", grant); end
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_mvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_mdata: got %h want 00", m_axis_tdata); end
      if (s_axis_tready !== 4'b0) begin n_err++; $display("FAIL mid_rst_sready: got %b want 0000", s_axis_tready); end
      if (abort !== 1'b0)         begin n_err++; $display("FAIL mid_rst_abort: got %b want 0", abort); end
      if (abort_port !== 2'd0)    begin n_err++; $display("FAIL mid_rst_abort_port: got %0d want 0", abort_port); end
      for (int i = 0; i < PORTS; i++) srcq[i].delete();
      exp_q.delete();
      rst_n = 1'b1;
      cycle();
   endtask

`ifdef UART_TX_ARB_SRC_HDR_EN
   task automatic test_header();
      do_reset();
      push_exp_hdr(2);
      push_beat(2, 8'h5A, 1'b1, 1'b1);
      drain(20);
      n_cmp++;
      if (xfer_cycs.size() != 2) begin
         n_err++;
         $display("FAIL hdr_count: got %0d want 2", xfer_cycs.size());
      end else begin
         n_cmp++;
         if (xfer_cycs[1] - xfer_cycs[0] !== 1) begin
            n_err++;
            $display("FAIL hdr_gap: got %0d want 1", xfer_cycs[1] - xfer_cycs[0]);
         end
      end
   endtask
`endif

   initial begin
      rst_n         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b1;
      test_reset();
      test_contention();
      test_single();
      test_round_robin();
      test_backpressure();
      test_watchdog();
`ifdef UART_TX_ARB_SRC_HDR_EN
      test_header();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmit stream between several AXI4-Stream byte sources. It sits directly in front of the UART's `s_axis` input. Each grant is held from the first byte of a source's packet until its `tlast` beat, so packets are never interleaved on the serial line. A stall watchdog releases a grant whose owner goes silent mid-packet.

## Interface
- `PORTS`, 4: number of requesting sources, 2..16.
- `DATA_WIDTH`, 8: byte width; must equal the UART `DATA_WIDTH`.
- `TIMEOUT`, 1024: cycles a granted source may hold `tvalid` low mid-packet before the grant is revoked; 0 disables the watchdog.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_axis_tdata` in PORTS*DATA_WIDTH: source data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid` in PORTS: per-source valid.
- `s_axis_tlast` in PORTS: per-source end-of-packet.
- `s_axis_tready` out PORTS: per-source ready.
- `m_axis_tdata` out DATA_WIDTH: byte to the UART.
- `m_axis_tvalid` out 1: valid to the UART.
- `m_axis_tready` in 1: ready from the UART.
- `grant` out PORTS: one-hot owner of the stream; all zero when idle.
- `abort` out 1: one-cycle pulse when the watchdog revokes a grant.
- `abort_port` out $clog2(PORTS): index of the revoked source; held until the next abort.

## Operation
- States are IDLE, HDR and PASS. HDR exists only when the configuration macro is defined.
- **IDLE**
  - `grant`=0, `m_axis_tvalid`=0 and all `s_axis_tready`=0.
  - If any `s_axis_tvalid` is high, select the first valid source scanning upward from `last+1` modulo PORTS, where `last` is the previous owner (reset value PORTS-1, so port 0 wins first).
  - Register `grant` and `last`, then go to PASS (or HDR).
- **PASS**
  - `m_axis_tdata`/`m_axis_tvalid` are combinationally muxed from the owner.
  - Only the owner sees `s_axis_tready` = `m_axis_tready`; every other source sees 0.
  - A beat transfers when `m_axis_tvalid && m_axis_tready`.
  - A transfer with the owner's `tlast`=1 returns to IDLE; `grant` clears next cycle.
- **Watchdog** (PASS only, TIMEOUT>0)
  - Counter width is $clog2(TIMEOUT+1).
  - The counter increments on each cycle where the owner's `tvalid`=0, and clears on any transfer and on entry to PASS.
  - When the counter reaches TIMEOUT: go to IDLE, pulse `abort` for one cycle and set `abort_port` to the owner.
  - `last` keeps the aborted owner, so the next scan starts after it.
- **Fairness:** with all sources continuously requesting, grants cycle 0,1,2,…,PORTS-1,0.
- **Reset:** reset mid-packet drops the packet silently. After reset, all outputs are 0, `abort_port`=0, `last`=PORTS-1 and the state is IDLE. No `abort` pulse is generated.

## Timing
- Arbitration latency is one cycle: a request seen in IDLE at cycle N gives `grant` and the first presented byte at N+1 (N+2 with the header).
- Zero-latency passthrough in PASS, so full throughput is one byte per cycle when the UART is ready.
- Per-packet overhead is one IDLE cycle between packets, even from the same source.
- A `tvalid` drop or `tready` drop mid-packet holds the grant; only the watchdog ends a non-`tlast` packet.
- A source raising `tvalid` in the same cycle the owner transfers `tlast` is considered in the next IDLE cycle, not that cycle.

## Configuration
- `UART_TX_ARB_SRC_HDR_EN` defined:
  - After the grant, the HDR state emits one header byte `{1'b1, zero-padded owner index}` (port 2 gives 8'h82 for DATA_WIDTH=8) with `m_axis_tvalid`=1 and all `s_axis_tready`=0.
  - The state moves to PASS when the header transfers.
  - The watchdog does not run in HDR.
- Not defined: the HDR state is absent and packets pass unmodified.

## Test plan
- Single source: port 1 sends 3 bytes 8'h11, 8'h22, 8'h33 (tlast on 8'h33) with UART always ready. Required: those bytes on `m_axis` in consecutive cycles, `grant`=4'b0010, then IDLE.
- Contention: ports 0 and 2 both hold 2-byte packets. Required: port 0's packet completes first, then port 2's, with no interleaving and one idle cycle between them.
- Round-robin: all 4 ports continuously send 1-byte packets. Required: grant order 0,1,2,3,0.
- Backpressure: `m_axis_tready` low for 5 cycles mid-packet. Required: owner's `s_axis_tready`=0, data held stable, no bytes lost, no abort.
- Watchdog with TIMEOUT=8: port 3 sends 1 byte without tlast, then drops `tvalid`. Required: `abort` pulses 8 cycles later with `abort_port`=3, a waiting port 0 is granted next, and a reset mid-packet yields all-zero outputs.
- With `UART_TX_ARB_SRC_HDR_EN`: port 2 sends byte 8'h5A. Required: `m_axis` carries 8'h82 then 8'h5A.
